// File: rtl/conv_layer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_scheduler_if
// Brief    : Control, configuration and beat-strobe bundle of the layer
//            scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_layer_scheduler_if #(
    parameter int STATE_WIDTH = 3,
    parameter int BEAT_WIDTH  = 16
);
    logic                   start;
    logic                   abort;
    logic [STATE_WIDTH:0]   cfg_layer_cnt;
    logic [BEAT_WIDTH-1:0]  cfg_weight_beats;
    logic [BEAT_WIDTH-1:0]  cfg_feat_beats;
    logic [BEAT_WIDTH-1:0]  cfg_out_beats;
    logic                   DDR_valid_in;
    logic                   MAC_data_valid_in;
    logic                   MAC_data_valid_out;
    logic                   weight_rd_req;
    logic                   feat_rd_en;
    logic [STATE_WIDTH-1:0] current_state;
    logic                   state_rst;
    logic [2:0]             phase;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        output start, abort, cfg_layer_cnt, cfg_weight_beats, cfg_feat_beats,
               cfg_out_beats, DDR_valid_in, MAC_data_valid_in, MAC_data_valid_out,
        input  weight_rd_req, feat_rd_en, current_state, state_rst, phase,
               busy, done, error
    );

    modport slave (
        input  start, abort, cfg_layer_cnt, cfg_weight_beats, cfg_feat_beats,
               cfg_out_beats, DDR_valid_in, MAC_data_valid_in, MAC_data_valid_out,
        output weight_rd_req, feat_rd_en, current_state, state_rst, phase,
               busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_scheduler
// Brief    : Steps the accelerator through weight load, compute and layer end
//            for each layer of a run, driving the shared layer index.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_scheduler #(
    parameter int STATE_WIDTH    = 3,
    parameter int BEAT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    conv_layer_scheduler_if.slave bus
);
    localparam int                    c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BEAT_WIDTH-1:0] c_BEAT_MAX  = '1;
    localparam logic [BEAT_WIDTH-1:0] c_BEAT_ONE  = BEAT_WIDTH'(1);
    localparam logic [STATE_WIDTH:0]  c_LAYER_ONE = (STATE_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WLOAD     = 3'd1,
        ST_COMPUTE   = 3'd2,
        ST_LAYER_END = 3'd3
    } state_t;

    state_t                 r_state, w_state;
    logic [STATE_WIDTH:0]   r_layer_cnt, w_layer_cnt;
    logic [BEAT_WIDTH-1:0]  r_w_beats, w_w_beats;
    logic [BEAT_WIDTH-1:0]  r_f_beats, w_f_beats;
    logic [BEAT_WIDTH-1:0]  r_o_beats, w_o_beats;
    logic [BEAT_WIDTH-1:0]  r_w_cnt, w_w_cnt;
    logic [BEAT_WIDTH-1:0]  r_in_cnt, w_in_cnt;
    logic [BEAT_WIDTH-1:0]  r_out_cnt, w_out_cnt;
    logic [c_WDOG_W-1:0]    r_wdog, w_wdog;
    logic [STATE_WIDTH-1:0] r_cur, w_cur;
    logic                   r_state_rst, w_state_rst;
    logic                   r_done, w_done;
    logic                   r_error, w_error;
    logic                   r_wreq, r_fen, r_busy;

    always_comb begin
        w_state     = r_state;
        w_layer_cnt = r_layer_cnt;
        w_w_beats   = r_w_beats;
        w_f_beats   = r_f_beats;
        w_o_beats   = r_o_beats;
        w_w_cnt     = r_w_cnt;
        w_in_cnt    = r_in_cnt;
        w_out_cnt   = r_out_cnt;
        w_wdog      = '0;
        w_cur       = r_cur;
        w_state_rst = 1'b0;
        w_done      = 1'b0;
        w_error     = r_error;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.cfg_layer_cnt == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_layer_cnt = bus.cfg_layer_cnt;
                        w_w_beats   = bus.cfg_weight_beats;
                        w_f_beats   = bus.cfg_feat_beats;
                        w_o_beats   = bus.cfg_out_beats;
                        w_w_cnt     = '0;
                        w_in_cnt    = '0;
                        w_out_cnt   = '0;
                        w_error     = 1'b0;
                        w_cur       = '0;
                        w_state_rst = 1'b1;
                        w_state     = (bus.cfg_weight_beats == '0) ? ST_COMPUTE : ST_WLOAD;
                    end
                end
            end
            ST_WLOAD: begin
                if (bus.DDR_valid_in) begin
                    if (r_w_cnt == r_w_beats - c_BEAT_ONE) begin
                        w_state = ST_COMPUTE;
                    end else if (r_w_cnt != c_BEAT_MAX) begin
                        w_w_cnt = r_w_cnt + c_BEAT_ONE;
                    end
                end
            end
            ST_COMPUTE: begin
                // Input beats past the configured count are dropped, so in_cnt never exceeds it
                if (bus.MAC_data_valid_in && (r_in_cnt < r_f_beats)) begin
                    w_in_cnt = r_in_cnt + c_BEAT_ONE;
                end
                if (bus.MAC_data_valid_out && (r_out_cnt != c_BEAT_MAX)) begin
                    w_out_cnt = r_out_cnt + c_BEAT_ONE;
                end
                if (r_o_beats != '0) begin
                    if (bus.MAC_data_valid_out && (r_out_cnt == r_o_beats - c_BEAT_ONE)) begin
                        w_state = ST_LAYER_END;
                    end
                end else if (w_in_cnt >= r_f_beats) begin
                    w_state = ST_LAYER_END;
                end
                if (!bus.MAC_data_valid_in && !bus.MAC_data_valid_out) begin
                    if (r_wdog == c_WDOG_LAST) begin
                        w_error     = 1'b1;
                        w_state_rst = 1'b1;
                        w_state     = ST_IDLE;
                    end else begin
                        w_wdog = r_wdog + 1'b1;
                    end
                end
            end
            ST_LAYER_END: begin
                w_w_cnt   = '0;
                w_in_cnt  = '0;
                w_out_cnt = '0;
                if ({1'b0, r_cur} == r_layer_cnt - c_LAYER_ONE) begin
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_cur       = r_cur + 1'b1;
                    w_state_rst = 1'b1;
                    w_state     = (r_w_beats == '0) ? ST_COMPUTE : ST_WLOAD;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state     = ST_IDLE;
            w_state_rst = 1'b1;
            w_done      = 1'b0;
            w_cur       = '0;
            w_w_cnt     = '0;
            w_in_cnt    = '0;
            w_out_cnt   = '0;
            w_wdog      = '0;
        end
    end

    // Request strobes are derived from the next state so they stay registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_layer_cnt <= '0;
            r_w_beats   <= '0;
            r_f_beats   <= '0;
            r_o_beats   <= '0;
            r_w_cnt     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wdog      <= '0;
            r_cur       <= '0;
            r_state_rst <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wreq      <= 1'b0;
            r_fen       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_layer_cnt <= w_layer_cnt;
            r_w_beats   <= w_w_beats;
            r_f_beats   <= w_f_beats;
            r_o_beats   <= w_o_beats;
            r_w_cnt     <= w_w_cnt;
            r_in_cnt    <= w_in_cnt;
            r_out_cnt   <= w_out_cnt;
            r_wdog      <= w_wdog;
            r_cur       <= w_cur;
            r_state_rst <= w_state_rst;
            r_done      <= w_done;
            r_error     <= w_error;
            r_wreq      <= (w_state == ST_WLOAD);
            r_fen       <= (w_state == ST_COMPUTE) && (w_in_cnt < w_f_beats);
            r_busy      <= (w_state != ST_IDLE);
        end
    end

    assign bus.weight_rd_req = r_wreq;
    assign bus.feat_rd_en    = r_fen;
    assign bus.current_state = r_cur;
    assign bus.state_rst     = r_state_rst;
    assign bus.phase         = r_state;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
endmodule
`default_nettype wire

// File: tb/tb_conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_scheduler
// Brief    : Directed vector table plus hand sequences for the layer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_scheduler;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    conv_layer_scheduler_if #(.STATE_WIDTH(3), .BEAT_WIDTH(16)) bus();

    conv_layer_scheduler #(
        .STATE_WIDTH(3), .BEAT_WIDTH(16), .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    typedef struct {
        logic st, ab, ddr, mi, mo;
        logic wreq, fen, srst, done;
        logic [2:0] cur, ph;
        logic busy;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t v(input logic st, ab, ddr, mi, mo, wreq, fen, srst, done,
                               input int cur, ph, input logic busy);
        vec_t r;
        r.st = st; r.ab = ab; r.ddr = ddr; r.mi = mi; r.mo = mo;
        r.wreq = wreq; r.fen = fen; r.srst = srst; r.done = done;
        r.cur = 3'(cur); r.ph = 3'(ph); r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, ab, ddr, mi, mo);
        bus.start = st; bus.abort = ab; bus.DDR_valid_in = ddr;
        bus.MAC_data_valid_in = mi; bus.MAC_data_valid_out = mo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int l, w, f, o);
        bus.cfg_layer_cnt = 4'(l); bus.cfg_weight_beats = 16'(w);
        bus.cfg_feat_beats = 16'(f); bus.cfg_out_beats = 16'(o);
    endtask

    task automatic chk_all(input string t, input logic wreq, fen, srst, done,
                           input int cur, ph, input logic busy, err);
        chk({t, ".wreq"}, 32'(bus.weight_rd_req), 32'(wreq));
        chk({t, ".fen"},  32'(bus.feat_rd_en),    32'(fen));
        chk({t, ".srst"}, 32'(bus.state_rst),     32'(srst));
        chk({t, ".done"}, 32'(bus.done),          32'(done));
        chk({t, ".cur"},  32'(bus.current_state), 32'(cur));
        chk({t, ".ph"},   32'(bus.phase),         32'(ph));
        chk({t, ".busy"}, 32'(bus.busy),          32'(busy));
        chk({t, ".err"},  32'(bus.error),         32'(err));
    endtask

    initial begin
        int  k;
        logic saw;

        drive(0, 0, 0, 0, 0);
        cfg(0, 0, 0, 0);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Two-layer run: weight=4, feat=6, out=3
        vecs.push_back(v(1,0,0,0,0, 1,0,1,0, 0,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 0,1,1));
        vecs.push_back(v(0,0,0,0,0, 1,0,0,0, 0,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 0,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 0,1,1));
        vecs.push_back(v(0,0,1,0,0, 0,1,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,1,0, 0,1,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,1,1, 0,1,0,0, 0,2,1));
        vecs.push_back(v(0,0,1,1,0, 0,1,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,1,0, 0,1,0,0, 0,2,1));
        vecs.push_back(v(1,0,0,1,0, 0,1,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,1,0, 0,0,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,1,0, 0,0,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,0,1, 0,0,0,0, 0,2,1));
        vecs.push_back(v(0,0,0,0,1, 0,0,0,0, 0,3,1));
        vecs.push_back(v(0,0,0,0,0, 1,0,1,0, 1,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 1,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 1,1,1));
        vecs.push_back(v(0,0,1,0,0, 1,0,0,0, 1,1,1));
        vecs.push_back(v(0,0,1,0,0, 0,1,0,0, 1,2,1));
        vecs.push_back(v(0,0,0,0,1, 0,1,0,0, 1,2,1));
        vecs.push_back(v(0,0,0,0,1, 0,1,0,0, 1,2,1));
        vecs.push_back(v(0,0,0,0,1, 0,0,0,0, 1,3,1));
        vecs.push_back(v(0,0,0,0,0, 0,0,0,1, 1,0,0));
        vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 1,0,0));

        cfg(2, 4, 6, 3);
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].ddr, vecs[i].mi, vecs[i].mo);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].wreq, vecs[i].fen, vecs[i].srst,
                    vecs[i].done, int'(vecs[i].cur), int'(vecs[i].ph), vecs[i].busy, 0);
        end

        // Zero-layer start: done only, never busy
        cfg(0, 4, 6, 3);
        drive(1, 0, 0, 0, 0); step();
        chk_all("zero0", 0, 0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0); step();
        chk_all("zero1", 0, 0, 0, 0, 1, 0, 0, 0);

        // No weight beats: straight into COMPUTE, out=0 ends on input count
        cfg(1, 0, 2, 0);
        saw = 1'b0;
        drive(1, 0, 0, 0, 0); step();
        saw |= bus.weight_rd_req;
        chk_all("now0", 0, 1, 1, 0, 0, 2, 1, 0);
        drive(0, 0, 0, 1, 0); step(); saw |= bus.weight_rd_req;
        chk("now1.ph", 32'(bus.phase), 2);
        step(); saw |= bus.weight_rd_req;
        chk_all("now2", 0, 0, 0, 0, 0, 3, 1, 0);
        drive(0, 0, 0, 0, 0); step(); saw |= bus.weight_rd_req;
        chk_all("now3", 0, 0, 0, 1, 0, 0, 0, 0);
        chk("now.wreq_seen", 32'(saw), 0);

        // Watchdog: exactly TIMEOUT_CYCLES idle cycles in COMPUTE
        cfg(1, 1, 2, 1);
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        chk("wd.enter", 32'(bus.phase), 2);
        drive(0, 0, 0, 0, 0);
        k = 0; saw = 1'b0;
        while (k < 5000 && !bus.error) begin
            step(); k++;
            saw |= bus.done;
        end
        chk("wd.cycles", 32'(k), 4096);
        chk_all("wd.trip", 0, 0, 1, 0, 0, 0, 0, 1);
        chk("wd.no_done", 32'(saw), 0);
        step();
        chk("wd.srst_clear", 32'(bus.state_rst), 0);
        chk("wd.sticky", 32'(bus.error), 1);
        drive(1, 0, 0, 0, 0); step();
        chk_all("wd.restart", 1, 0, 1, 0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();

        // Abort in WLOAD of layer 1 after 2 of 4 beats
        cfg(2, 4, 1, 1);
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0);
        repeat (4) step();
        chk("ab.compute", 32'(bus.phase), 2);
        drive(0, 0, 0, 0, 1); step();
        chk("ab.lend", 32'(bus.phase), 3);
        drive(0, 0, 0, 0, 0); step();
        chk_all("ab.l1", 1, 0, 1, 0, 1, 1, 1, 0);
        drive(0, 0, 1, 0, 0); step(); step();
        drive(0, 1, 0, 0, 0); step();
        chk_all("ab.abort", 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0); step();
        chk("ab.srst_once", 32'(bus.state_rst), 0);
        drive(1, 0, 0, 0, 0); step();
        chk_all("ab.rerun", 1, 0, 1, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        repeat (3) step();
        chk("ab.fresh3", 32'(bus.phase), 1);
        step();
        chk("ab.fresh4", 32'(bus.phase), 2);
        drive(0, 1, 0, 0, 0); step();
        drive(1, 1, 0, 0, 0); step();
        chk_all("ab.idle_both", 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        cfg(1, 2, 2, 2);
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();
        #2 rstn = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("arst.idle", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
